// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Bundles the two request channels, the two response channels
//               and the shared-ALU connection of alu_share_arbiter.
//               slave  -> the arbiter side
//               master -> the requesters / ALU side
// Signals     : reqN_valid/ready/a/b/op  request channel per port
//               rspN_valid/ready         response channel per port
//               rsp_c, rsp_f             shared captured result and flag
//               alu_a/b/op -> ALU,  alu_c/f <- ALU,  busy
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_op;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_c;
  logic              rsp_f;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_c;
  logic              alu_f;
  logic              busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_c, rsp_f,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_c, alu_f,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_c, rsp_f,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_c, alu_f,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter/sequencer time-sharing one combinational
//               ALU between two requesters. One operation in flight:
//               IDLE (grant + latch operands) -> EXEC (capture ALU result)
//               -> RESP (hold result until the granted port consumes it).
// Ports       : clk    system clock, rising edge
//               rst_n  asynchronous active-low reset
//               bus    alu_share_arbiter_if.slave (requests, responses, ALU)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_W    = 32,
  parameter bit PRIO_INIT = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [3:0]        op_code_q, op_code_d;
  logic [DATA_W-1:0] rsp_c_q, rsp_c_d;
  logic              rsp_f_q, rsp_f_d;

  logic w_idle;
  logic w_any_req;
  logic w_sel;

  // Port selected in IDLE: the lone requester, or the priority port when
  // both ask. Depends only on request valids and prio, never on ALU data.
  assign w_idle    = (state_q == ST_IDLE);
  assign w_any_req = bus.req0_valid | bus.req1_valid;
  assign w_sel     = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    gnt_d     = gnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    rsp_c_d   = rsp_c_q;
    rsp_f_d   = rsp_f_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          gnt_d     = w_sel;
          op_a_d    = w_sel ? bus.req1_a  : bus.req0_a;
          op_b_d    = w_sel ? bus.req1_b  : bus.req0_b;
          op_code_d = w_sel ? bus.req1_op : bus.req0_op;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU inputs have been stable from the operand registers all cycle.
        rsp_c_d = bus.alu_c;
        rsp_f_d = bus.alu_f;
        prio_d  = ~gnt_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Only the granted port's rsp_ready can release the response.
        if (gnt_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prio_q    <= PRIO_INIT;
      gnt_q     <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= 4'd0;
      rsp_c_q   <= '0;
      rsp_f_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      rsp_c_q   <= rsp_c_d;
      rsp_f_q   <= rsp_f_d;
    end
  end

  assign bus.req0_ready = w_idle & bus.req0_valid & ~w_sel;
  assign bus.req1_ready = w_idle & bus.req1_valid &  w_sel;
  assign bus.rsp0_valid = (state_q == ST_RESP) & ~gnt_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) &  gnt_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_f      = rsp_f_q;
  assign bus.alu_a      = op_a_q;
  assign bus.alu_b      = op_b_q;
  assign bus.alu_op     = op_code_q;
  assign bus.busy       = ~w_idle;

endmodule
`default_nettype wire
